// File: rtl/dzcpu_useq_pkg.sv
// ----------------------------------------------------------------------------
// dzcpu_useq_pkg : shared micro-op field layout, op codes and sequencer states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dzcpu_useq_pkg;

  // Flow nibble bit positions (within the 4-bit flow field)
  localparam int FLOW_INC = 3;
  localparam int FLOW_EOF = 2;

  localparam logic [1:0] COND_NONE = 2'b00;
  localparam logic [1:0] COND_FU   = 2'b01;
  localparam logic [1:0] COND_Z    = 2'b10;
  localparam logic [1:0] COND_NZ   = 2'b11;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_SMA   = 4'h1;
  localparam logic [3:0] OP_SMW   = 4'h2;
  localparam logic [3:0] OP_SRM   = 4'h3;
  localparam logic [3:0] OP_INC16 = 4'h4;
  localparam logic [3:0] OP_DEC16 = 4'h5;
  localparam logic [3:0] OP_JCB   = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EXEC   = 2'd2,
    ST_CBWAIT = 2'd3
  } useq_state_e;

  function automatic logic eff_eof(input logic eof, input logic [1:0] cond,
                                   input logic flag_z);
    logic cond_ok;
    cond_ok = (cond == COND_NONE) || (cond == COND_FU) ||
              ((cond == COND_Z) && flag_z) || ((cond == COND_NZ) && !flag_z);
    return eof && cond_ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dzcpu_uop_decode.sv
// ----------------------------------------------------------------------------
// dzcpu_uop_decode : combinational micro-op field split and effective-eof
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dzcpu_uop_decode
  import dzcpu_useq_pkg::*;
#(
  parameter int UOP_W = 13
) (
  input  logic [UOP_W-1:0] i_uop,
  input  logic             i_flag_z,
  output logic             o_inc,
  output logic             o_eof_eff,
  output logic             o_flag_upd,
  output logic             o_is_jcb,
  output logic [3:0]       o_op,
  output logic [4:0]       o_operand
);

  logic [3:0] w_flow;
  logic [1:0] w_cond;

  assign w_flow     = i_uop[UOP_W-1 -: 4];
  assign w_cond     = w_flow[1:0];
  assign o_op       = i_uop[8:5];
  assign o_operand  = i_uop[4:0];
  assign o_inc      = w_flow[FLOW_INC];
  assign o_flag_upd = (w_cond == COND_FU);
  assign o_is_jcb   = (o_op == OP_JCB);
  assign o_eof_eff  = eff_eof(w_flow[FLOW_EOF], w_cond, i_flag_z);

endmodule

`default_nettype wire

// File: rtl/dzcpu_useq.sv
// ----------------------------------------------------------------------------
// dzcpu_useq : opcode -> micro-flow sequencer, steps micro-PC and issues strobes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int UPC_W = 8,
  parameter int UOP_W = 13
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMemData,
  input  logic             iMemValid,
  input  logic             iStall,
  input  logic             iFlagZ,
  output logic [7:0]       oLutMop,
  input  logic [UPC_W-1:0] iLutIdx,
  input  logic [UPC_W-1:0] iCbLutIdx,
  output logic [UPC_W-1:0] oRomAddr,
  input  logic [UOP_W-1:0] iRomUop,
  output logic             oUopValid,
  output logic [3:0]       oOp,
  output logic [4:0]       oOperand,
  output logic             oPcInc,
  output logic             oFlagUpdate,
  output logic             oMopDone,
  output logic             oUpcOvf
);

  useq_state_e      state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic             cb_sel_q, cb_sel_d;
  logic             ovf_q, ovf_d;

  logic [UPC_W-1:0] w_upc;
  logic             w_valid, w_step;
  logic             w_inc, w_eof_eff, w_flag_upd, w_is_jcb;
  logic [3:0]       w_op;
  logic [4:0]       w_operand;

  // The first CB micro-op is addressed straight from the CB table (indexed by
  // the latched IR) so it issues one cycle after the CB byte arrives.
  assign w_upc    = cb_sel_q ? iCbLutIdx : upc_q;
  assign oRomAddr = w_upc;
  assign oLutMop  = ir_q;

  dzcpu_uop_decode #(
    .UOP_W (UOP_W)
  ) u_decode (
    .i_uop      (iRomUop),
    .i_flag_z   (iFlagZ),
    .o_inc      (w_inc),
    .o_eof_eff  (w_eof_eff),
    .o_flag_upd (w_flag_upd),
    .o_is_jcb   (w_is_jcb),
    .o_op       (w_op),
    .o_operand  (w_operand)
  );

  assign w_valid     = (state_q == ST_EXEC);
  assign w_step      = w_valid && !iStall;
  assign oUopValid   = w_valid;
  assign oOp         = w_valid ? w_op : OP_NOP;
  assign oOperand    = w_valid ? w_operand : 5'd0;
  assign oPcInc      = w_inc && w_valid;
  assign oFlagUpdate = w_flag_upd && w_valid;
  assign oMopDone    = w_step && !w_is_jcb && w_eof_eff;
  assign oUpcOvf     = ovf_q;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    upc_d    = upc_q;
    cb_sel_d = cb_sel_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_FETCH: begin
        if (iMemValid) begin
          ir_d    = iMemData;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        upc_d   = iLutIdx;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!iStall) begin
          cb_sel_d = 1'b0;
          upc_d    = w_upc;
          if (w_is_jcb) begin
            state_d = ST_CBWAIT;
          end else if (w_eof_eff) begin
            state_d = ST_FETCH;
          end else if (w_upc == {UPC_W{1'b1}}) begin
            // Running off the end of the ROM aborts the flow silently.
            ovf_d   = 1'b1;
            upc_d   = '0;
            state_d = ST_FETCH;
          end else begin
            upc_d = w_upc + 1'b1;
          end
        end
      end
      ST_CBWAIT: begin
        if (iMemValid) begin
          ir_d     = iMemData;
          cb_sel_d = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      upc_q    <= '0;
      cb_sel_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      upc_q    <= upc_d;
      cb_sel_q <= cb_sel_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dzcpu_useq.sv
// ----------------------------------------------------------------------------
// tb_dzcpu_useq : directed vector bench with a small ROM/LUT model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dzcpu_useq;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic [7:0]  iMemData = 8'h00;
  logic        iMemValid = 1'b0;
  logic        iStall = 1'b0;
  logic        iFlagZ = 1'b0;
  logic [7:0]  oLutMop;
  logic [7:0]  iLutIdx;
  logic [7:0]  iCbLutIdx;
  logic [7:0]  oRomAddr;
  logic [12:0] iRomUop;
  logic        oUopValid;
  logic [3:0]  oOp;
  logic [4:0]  oOperand;
  logic        oPcInc;
  logic        oFlagUpdate;
  logic        oMopDone;
  logic        oUpcOvf;

  dzcpu_useq #(.UPC_W(8), .UOP_W(13)) dut (
    .iClock(iClock), .iReset(iReset), .iMemData(iMemData), .iMemValid(iMemValid),
    .iStall(iStall), .iFlagZ(iFlagZ), .oLutMop(oLutMop), .iLutIdx(iLutIdx),
    .iCbLutIdx(iCbLutIdx), .oRomAddr(oRomAddr), .iRomUop(iRomUop),
    .oUopValid(oUopValid), .oOp(oOp), .oOperand(oOperand), .oPcInc(oPcInc),
    .oFlagUpdate(oFlagUpdate), .oMopDone(oMopDone), .oUpcOvf(oUpcOvf)
  );

  always #5 iClock = ~iClock;

  logic [12:0] rom [256];

  function automatic logic [12:0] uop(input logic [3:0] flow, input logic [3:0] op,
                                      input logic [4:0] opr);
    return {flow, op, opr};
  endfunction

  function automatic logic [7:0] lut_main(input logic [7:0] m);
    case (m)
      8'h31:   return 8'd1;
      8'hCB:   return 8'd13;
      8'h20:   return 8'd17;
      8'h28:   return 8'd30;
      8'h40:   return 8'd56;
      8'hFE:   return 8'd254;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] lut_cb(input logic [7:0] m);
    return (m == 8'h7C) ? 8'd16 : 8'd0;
  endfunction

  assign iRomUop   = rom[oRomAddr];
  assign iLutIdx   = lut_main(oLutMop);
  assign iCbLutIdx = lut_cb(oLutMop);

  typedef struct {
    logic       rst_n, mv, st, fz;
    logic [7:0] md;
    logic       v, acare;
    logic [7:0] addr;
    logic [3:0] op;
    logic       pci, fu, done, ovf;
  } vec_t;

  vec_t vecs [80];
  int   nv = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic add(input logic rst_n, input logic mv, input logic [7:0] md,
                     input logic st, input logic fz, input logic v,
                     input logic [7:0] addr, input logic acare, input logic [3:0] op,
                     input logic pci, input logic fu, input logic done, input logic ovf);
    vecs[nv].rst_n = rst_n; vecs[nv].mv = mv; vecs[nv].md = md;
    vecs[nv].st = st; vecs[nv].fz = fz; vecs[nv].v = v;
    vecs[nv].addr = addr; vecs[nv].acare = acare; vecs[nv].op = op;
    vecs[nv].pci = pci; vecs[nv].fu = fu; vecs[nv].done = done; vecs[nv].ovf = ovf;
    nv++;
  endtask

  // Idle cycle (FETCH/LOOKUP/CBWAIT): no strobes, micro-PC not checked.
  task automatic idle(input logic rst_n, input logic mv, input logic [7:0] md,
                      input logic ovf);
    add(rst_n, mv, md, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, ovf);
  endtask

  // Post-reset cycle: FETCH with micro-PC checked at 0.
  task automatic vz(input logic ovf);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, ovf);
  endtask

  task automatic ex(input logic mv, input logic [7:0] md, input logic st, input logic fz,
                    input logic [7:0] addr, input logic [3:0] op, input logic pci,
                    input logic fu, input logic done, input logic ovf);
    add(1'b1, mv, md, st, fz, 1'b1, addr, 1'b1, op, pci, fu, done, ovf);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] act, exp;
    logic        seen;
    int          lat;

    for (int i = 0; i < 256; i++) rom[i] = uop(4'b1100, 4'h0, 5'd0);
    rom[1]   = uop(4'b1000, 4'h3, 5'd1);
    rom[2]   = uop(4'b1000, 4'h3, 5'd2);
    rom[3]   = uop(4'b0000, 4'h4, 5'd3);
    rom[4]   = uop(4'b1100, 4'h0, 5'd0);
    rom[13]  = uop(4'b1000, 4'h1, 5'd0);
    rom[14]  = uop(4'b0000, 4'h2, 5'd1);
    rom[15]  = uop(4'b1000, 4'hF, 5'd0);
    rom[16]  = uop(4'b0101, 4'h6, 5'd7);
    rom[17]  = uop(4'b1000, 4'h3, 5'd4);
    rom[18]  = uop(4'b0000, 4'h7, 5'd0);
    rom[19]  = uop(4'b0110, 4'h8, 5'd0);
    rom[20]  = uop(4'b0000, 4'h9, 5'd0);
    rom[21]  = uop(4'b0000, 4'hA, 5'd0);
    rom[22]  = uop(4'b1100, 4'h0, 5'd0);
    rom[30]  = uop(4'b0111, 4'h3, 5'd0);
    rom[31]  = uop(4'b0100, 4'h0, 5'd0);
    rom[56]  = uop(4'b0000, 4'h1, 5'd5);
    rom[57]  = uop(4'b0100, 4'h2, 5'd0);
    rom[254] = uop(4'b0000, 4'h0, 5'd0);
    rom[255] = uop(4'b0000, 4'h0, 5'd0);

    // Reset state, then LD SP,nn (stray iMemValid mid-flow must be ignored)
    vz(1'b0);
    idle(1, 1, 8'h31, 0); idle(1, 0, 8'h00, 0);
    ex(1, 8'hCB, 0, 0, 8'd1, 4'h3, 1, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd2, 4'h3, 1, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd3, 4'h4, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd4, 4'h0, 1, 0, 1, 0);
    idle(1, 0, 8'h00, 0);
    // CB prefix then BIT 7,H
    idle(1, 1, 8'hCB, 0); idle(1, 0, 8'h00, 0);
    ex(0, 8'h00, 0, 0, 8'd13, 4'h1, 1, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd14, 4'h2, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd15, 4'hF, 1, 0, 0, 0);
    idle(1, 0, 8'h00, 0); idle(1, 1, 8'h7C, 0);
    ex(0, 8'h00, 0, 0, 8'd16, 4'h6, 0, 1, 1, 0);
    idle(1, 0, 8'h00, 0);
    // JR NZ with Z=1: ends at 19
    idle(1, 1, 8'h20, 0); idle(1, 0, 8'h00, 0);
    ex(0, 8'h00, 0, 0, 8'd17, 4'h3, 1, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd18, 4'h7, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 1, 8'd19, 4'h8, 0, 0, 1, 0);
    idle(1, 0, 8'h00, 0);
    // JR NZ with Z=0: runs to 22
    idle(1, 1, 8'h20, 0); idle(1, 0, 8'h00, 0);
    ex(0, 8'h00, 0, 0, 8'd17, 4'h3, 1, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd18, 4'h7, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd19, 4'h8, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 1, 8'd20, 4'h9, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd21, 4'hA, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd22, 4'h0, 1, 0, 1, 0);
    idle(1, 0, 8'h00, 0);
    // nz-conditional eof with Z=1 does not end the flow
    idle(1, 1, 8'h28, 0); idle(1, 0, 8'h00, 0);
    ex(0, 8'h00, 0, 1, 8'd30, 4'h3, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 1, 8'd31, 4'h0, 0, 0, 1, 0);
    idle(1, 0, 8'h00, 0);
    // Stall 3 cycles at 56, then 1 cycle on the eof micro-op 57
    idle(1, 1, 8'h40, 0); idle(1, 0, 8'h00, 0);
    ex(0, 8'h00, 1, 0, 8'd56, 4'h1, 0, 0, 0, 0);
    ex(0, 8'h00, 1, 0, 8'd56, 4'h1, 0, 0, 0, 0);
    ex(0, 8'h00, 1, 0, 8'd56, 4'h1, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd56, 4'h1, 0, 0, 0, 0);
    ex(0, 8'h00, 1, 0, 8'd57, 4'h2, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd57, 4'h2, 0, 0, 1, 0);
    idle(1, 0, 8'h00, 0);
    // Reset mid-flow at uPC 20
    idle(1, 1, 8'h20, 0); idle(1, 0, 8'h00, 0);
    ex(0, 8'h00, 0, 0, 8'd17, 4'h3, 1, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd18, 4'h7, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd19, 4'h8, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'd20, 1, 4'h9, 0, 0, 0, 0);
    vz(1'b0); vz(1'b0);
    // Micro-PC overflow, stickiness, unmapped opcode -> flow 0, clear by reset
    idle(1, 1, 8'hFE, 0); idle(1, 0, 8'h00, 0);
    ex(0, 8'h00, 0, 0, 8'd254, 4'h0, 0, 0, 0, 0);
    ex(0, 8'h00, 0, 0, 8'd255, 4'h0, 0, 0, 0, 0);
    idle(1, 0, 8'h00, 1); idle(1, 1, 8'h00, 1); idle(1, 0, 8'h00, 1);
    ex(0, 8'h00, 0, 0, 8'd0, 4'h0, 1, 0, 1, 1);
    idle(0, 0, 8'h00, 1);
    vz(1'b0);

    iReset = 1'b0;
    repeat (2) @(posedge iClock);

    for (int i = 0; i < nv; i++) begin
      @(negedge iClock);
      iReset    = vecs[i].rst_n;
      iMemValid = vecs[i].mv;
      iMemData  = vecs[i].md;
      iStall    = vecs[i].st;
      iFlagZ    = vecs[i].fz;
      #1;
      act = {15'd0, oUopValid, (vecs[i].acare || vecs[i].v) ? oRomAddr : 8'h00,
             vecs[i].v ? oOp : 4'h0, oPcInc, oFlagUpdate, oMopDone, oUpcOvf};
      exp = {15'd0, vecs[i].v, vecs[i].addr, vecs[i].op, vecs[i].pci, vecs[i].fu,
             vecs[i].done, vecs[i].ovf};
      check($sformatf("vec%0d {valid,addr,op,pcinc,fu,done,ovf}", i), act, exp);
    end

    // jcb held under stall: stays issued, never leaves EXEC, then CB wait
    @(negedge iClock); iReset = 1'b1; iMemValid = 1'b1; iMemData = 8'hCB;
    iStall = 1'b0; iFlagZ = 1'b0;
    @(negedge iClock); iMemValid = 1'b0;
    @(negedge iClock);
    @(negedge iClock);
    for (int k = 0; k < 4; k++) begin
      @(negedge iClock); iStall = (k < 3);
      #1;
      check($sformatf("jcb_stall%0d {valid,addr,op,pcinc,done}", k),
            {oUopValid, oRomAddr, oOp, oPcInc, oMopDone}, {1'b1, 8'd15, 4'hF, 1'b1, 1'b0});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge iClock); iStall = 1'b0;
      #1;
      check($sformatf("cbwait_idle%0d valid", k), {31'd0, oUopValid}, 32'd0);
    end
    iMemValid = 1'b1; iMemData = 8'h7C;
    @(negedge iClock); iMemValid = 1'b0;
    #1;
    check("cb_first {valid,addr,fu,done}", {oUopValid, oRomAddr, oFlagUpdate, oMopDone},
          {1'b1, 8'd16, 1'b1, 1'b1});

    // Bounded wait for LD SP,nn completion: done 5 cycles after iMemValid
    @(negedge iClock); iMemValid = 1'b1; iMemData = 8'h31;
    seen = 1'b0; lat = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge iClock); iMemValid = 1'b0;
      #1;
      if (oMopDone) begin seen = 1'b1; lat = c; end
    end
    check("ldsp_done_latency", lat, 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
